// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - maze player position controller with wall-map lookup
// Samples buttons on move_tick, checks the target cell's wall bit, then commits or rejects the move.
module player_ctrl #(
    parameter int COLS      = 32,
    parameter int ROWS      = 24,
    parameter int START_ROW = 2,
    parameter int START_COL = 10,
    parameter int GOAL_ROW  = 21,
    parameter int GOAL_COL  = 30,
    parameter int RD_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic       game_en,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       wall_rd,
    output logic [9:0] wall_addr,
    input  logic       wall_data,
    output logic [4:0] row_pos,
    output logic [4:0] col_pos,
    output logic       busy,
    output logic       goal_reached,
    output logic [9:0] step_count
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, DONE} state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

    state_t     state, state_nxt;
    logic [4:0] tgt_row, tgt_col, tgt_row_nxt, tgt_col_nxt;
    logic [1:0] wait_cnt, wait_cnt_nxt;
    logic [4:0] row_nxt, col_nxt;
    logic [9:0] steps_nxt;
    logic       goal_nxt;
    logic [4:0] cand_row, cand_col;
    logic       cand_ok;
    logic [9:0] addr_nxt;

    // Edge cells are tested before the +/-1 so a blocked move never wraps.
    always_comb begin
        cand_row = row_pos;
        cand_col = col_pos;
        cand_ok  = 1'b1;
        if (btn_up) begin
            if (row_pos == 5'd0) cand_ok = 1'b0;
            else                 cand_row = row_pos - 5'd1;
        end else if (btn_down) begin
            if (row_pos == 5'(ROWS - 1)) cand_ok = 1'b0;
            else                         cand_row = row_pos + 5'd1;
        end else if (btn_left) begin
            if (col_pos == 5'd0) cand_ok = 1'b0;
            else                 cand_col = col_pos - 5'd1;
        end else if (btn_right) begin
            if (col_pos == 5'(COLS - 1)) cand_ok = 1'b0;
            else                         cand_col = col_pos + 5'd1;
        end else begin
            cand_ok = 1'b0;
        end
    end

    assign addr_nxt = 10'(cand_row) * 10'(COLS) + 10'(cand_col);

    always_comb begin
        state_nxt    = state;
        tgt_row_nxt  = tgt_row;
        tgt_col_nxt  = tgt_col;
        wait_cnt_nxt = wait_cnt;
        row_nxt      = row_pos;
        col_nxt      = col_pos;
        steps_nxt    = step_count;
        goal_nxt     = goal_reached;
        case (state)
            IDLE: begin
                if (move_tick && game_en && cand_ok) begin
                    tgt_row_nxt = cand_row;
                    tgt_col_nxt = cand_col;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                wait_cnt_nxt = 2'd0;
                state_nxt    = (RD_LAT > 1) ? WAIT : CHECK;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) state_nxt = CHECK;
                else                       wait_cnt_nxt = wait_cnt + 2'd1;
            end
            CHECK: begin
                state_nxt = IDLE;
                if (!wall_data) begin
                    row_nxt = tgt_row;
                    col_nxt = tgt_col;
                    if (step_count != 10'h3FF) steps_nxt = step_count + 10'd1;
                    if (tgt_row == 5'(GOAL_ROW) && tgt_col == 5'(GOAL_COL)) begin
                        goal_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe and busy are registered from the next state so they line up with REQ..CHECK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tgt_row      <= 5'd0;
            tgt_col      <= 5'd0;
            wait_cnt     <= 2'd0;
            row_pos      <= 5'(START_ROW);
            col_pos      <= 5'(START_COL);
            step_count   <= 10'd0;
            goal_reached <= 1'b0;
            busy         <= 1'b0;
            wall_rd      <= 1'b0;
            wall_addr    <= 10'd0;
        end else begin
            state        <= state_nxt;
            tgt_row      <= tgt_row_nxt;
            tgt_col      <= tgt_col_nxt;
            wait_cnt     <= wait_cnt_nxt;
            row_pos      <= row_nxt;
            col_pos      <= col_nxt;
            step_count   <= steps_nxt;
            goal_reached <= goal_nxt;
            busy         <= (state_nxt == REQ) || (state_nxt == WAIT) || (state_nxt == CHECK);
            wall_rd      <= (state_nxt == REQ);
            if (state == IDLE && state_nxt == REQ) wall_addr <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// tb/tb_player_ctrl.sv - self-checking bench for player_ctrl (RD_LAT=1 and RD_LAT=3 instances)
module tb_player_ctrl;

    logic       clk = 1'b0;
    logic       rst, rst3;
    logic       move_tick, tick3, game_en;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       wall_rd, wall_data, busy, goal_reached;
    logic [9:0] wall_addr, step_count;
    logic [4:0] row_pos, col_pos;
    logic       wall_rd3, wall_data3, busy3, goal3;
    logic [9:0] wall_addr3, steps3;
    logic [4:0] row3, col3;

    bit   wall_map [0:1023];
    logic d1, d2;
    int   checks = 0;
    int   errors = 0;
    int   sb_q[$];
    int   m_row, m_col, m_steps;
    bit   m_goal;

    always #5 clk = ~clk;

    player_ctrl #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .game_en(game_en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .wall_rd(wall_rd), .wall_addr(wall_addr), .wall_data(wall_data),
        .row_pos(row_pos), .col_pos(col_pos), .busy(busy),
        .goal_reached(goal_reached), .step_count(step_count)
    );

    player_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .move_tick(tick3), .game_en(game_en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .wall_rd(wall_rd3), .wall_addr(wall_addr3), .wall_data(wall_data3),
        .row_pos(row3), .col_pos(col3), .busy(busy3),
        .goal_reached(goal3), .step_count(steps3)
    );

    always @(posedge clk) wall_data <= wall_rd ? wall_map[wall_addr] : 1'b0;

    always @(posedge clk) begin
        d1         <= wall_rd3 ? wall_map[wall_addr3] : 1'b0;
        d2         <= d1;
        wall_data3 <= d2;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wall_rd) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wall_rd: got addr %0d expected no read", wall_addr);
            end else begin
                chk("wall_addr", 32'(wall_addr), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic apply(input string nm, input logic [3:0] btn, input bit wall, input bit acc,
                         input int addr, input int er, input int ec, input int es, input bit eg);
        int bc;
        if (acc) begin
            wall_map[addr] = wall;
            sb_q.push_back(addr);
        end
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = btn;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        chk({nm, ".wall_rd"}, 32'(wall_rd), 32'(acc));
        bc = int'(busy);
        repeat (3) begin
            @(negedge clk);
            bc += int'(busy);
        end
        chk({nm, ".busy_cycles"}, 32'(bc), acc ? 32'd2 : 32'd0);
        chk({nm, ".row"}, 32'(row_pos), 32'(er));
        chk({nm, ".col"}, 32'(col_pos), 32'(ec));
        chk({nm, ".steps"}, 32'(step_count), 32'(es));
        chk({nm, ".goal"}, 32'(goal_reached), 32'(eg));
    endtask

    task automatic model_move(input string nm, input logic [3:0] btn, input bit wall);
        int tr, tc;
        bit acc;
        tr  = m_row;
        tc  = m_col;
        acc = 1'b1;
        if (btn[3])      begin if (m_row == 0)  acc = 1'b0; else tr = m_row - 1; end
        else if (btn[2]) begin if (m_row == 23) acc = 1'b0; else tr = m_row + 1; end
        else if (btn[1]) begin if (m_col == 0)  acc = 1'b0; else tc = m_col - 1; end
        else if (btn[0]) begin if (m_col == 31) acc = 1'b0; else tc = m_col + 1; end
        else acc = 1'b0;
        if (m_goal) acc = 1'b0;
        if (acc && !wall) begin
            m_row = tr;
            m_col = tc;
            m_steps++;
            if (tr == 21 && tc == 30) m_goal = 1'b1;
        end
        apply(nm, btn, wall, acc, tr * 32 + tc, m_row, m_col, m_steps, m_goal);
    endtask

    task automatic walk(input string nm, input logic [3:0] btn, input int n);
        for (int i = 0; i < n; i++) model_move(nm, btn, 1'b0);
    endtask

    typedef struct {
        logic [3:0] btn;
        bit         wall;
        bit         acc;
        int         addr;
        int         row;
        int         col;
        int         steps;
    } vec_t;

    initial begin
        vec_t tbl [8];
        int   bc;
        logic seen;

        // btn = {up, down, left, right}
        tbl[0] = '{4'b1000, 1'b1, 1'b1,  42, 2, 10, 0};
        tbl[1] = '{4'b0001, 1'b0, 1'b1,  75, 2, 11, 1};
        tbl[2] = '{4'b1010, 1'b0, 1'b1,  43, 1, 11, 2};
        tbl[3] = '{4'b0100, 1'b0, 1'b1,  75, 2, 11, 3};
        tbl[4] = '{4'b0010, 1'b0, 1'b1,  74, 2, 10, 4};
        tbl[5] = '{4'b0101, 1'b1, 1'b1, 106, 2, 10, 4};
        tbl[6] = '{4'b0011, 1'b0, 1'b1,  73, 2,  9, 5};
        tbl[7] = '{4'b0000, 1'b0, 1'b0,   0, 2,  9, 5};

        rst = 1'b0; rst3 = 1'b0; move_tick = 1'b0; tick3 = 1'b0; game_en = 1'b1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst.row", 32'(row_pos), 32'd2);
        chk("rst.col", 32'(col_pos), 32'd10);
        chk("rst.steps", 32'(step_count), 32'd0);
        chk("rst.goal", 32'(goal_reached), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.wall_rd", 32'(wall_rd), 32'd0);
        chk("rst.wall_addr", 32'(wall_addr), 32'd0);
        rst = 1'b1; rst3 = 1'b1;

        // RD_LAT=3: full-latency move, then reset while waiting on the read
        @(negedge clk);
        btn_right = 1'b1; tick3 = 1'b1;
        @(negedge clk);
        tick3 = 1'b0; btn_right = 1'b0;
        chk("lat3.wall_rd", 32'(wall_rd3), 32'd1);
        chk("lat3.wall_addr", 32'(wall_addr3), 32'd75);
        bc = int'(busy3);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            bc += int'(busy3);
            if (i == 4) chk("lat3.col_before_commit", 32'(col3), 32'd10);
        end
        chk("lat3.col", 32'(col3), 32'd11);
        chk("lat3.busy_cycles", 32'(bc), 32'd4);
        chk("lat3.steps", 32'(steps3), 32'd1);

        @(negedge clk);
        btn_right = 1'b1; tick3 = 1'b1;
        @(negedge clk);
        tick3 = 1'b0; btn_right = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("abort.col", 32'(col3), 32'd10);
        chk("abort.steps", 32'(steps3), 32'd0);
        chk("abort.busy", 32'(busy3), 32'd0);
        chk("abort.wall_rd", 32'(wall_rd3), 32'd0);
        chk("abort.wall_addr", 32'(wall_addr3), 32'd0);
        @(negedge clk);
        rst3 = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | wall_rd3 | busy3;
        end
        chk("abort.no_activity", 32'(seen), 32'd0);
        chk("abort.late_col", 32'(col3), 32'd10);
        chk("abort.late_steps", 32'(steps3), 32'd0);

        // RD_LAT=1 instance
        game_en = 1'b0;
        apply("game_off", 4'b0001, 1'b0, 1'b0, 0, 2, 10, 0, 1'b0);
        game_en = 1'b1;

        for (int i = 0; i < 8; i++)
            apply($sformatf("vec%0d", i), tbl[i].btn, tbl[i].wall, tbl[i].acc,
                  tbl[i].addr, tbl[i].row, tbl[i].col, tbl[i].steps, 1'b0);

        // Second tick while busy must be dropped: one read only
        wall_map[41] = 1'b0;
        sb_q.push_back(41);
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = 4'b1010;
        move_tick = 1'b1;
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0001;
        @(negedge clk);
        move_tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        repeat (3) @(negedge clk);
        chk("busy_tick.pending_reads", 32'(sb_q.size()), 32'd0);
        chk("busy_tick.row", 32'(row_pos), 32'd1);
        chk("busy_tick.col", 32'(col_pos), 32'd9);
        chk("busy_tick.steps", 32'(step_count), 32'd6);

        m_row = 1; m_col = 9; m_steps = 6; m_goal = 1'b0;
        walk("to_top", 4'b1000, 1);
        walk("to_col5", 4'b0010, 4);
        model_move("edge_up", 4'b1000, 1'b0);
        walk("to_bottom", 4'b0100, 23);
        model_move("edge_down", 4'b0100, 1'b0);
        walk("to_right", 4'b0001, 26);
        model_move("edge_right", 4'b0001, 1'b0);
        walk("to_goal_col", 4'b0010, 2);
        walk("to_goal_row", 4'b1000, 2);
        model_move("enter_goal", 4'b0001, 1'b0);
        chk("goal.flag", 32'(goal_reached), 32'd1);
        model_move("done_right", 4'b0001, 1'b0);
        model_move("done_left", 4'b0010, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rerst.row", 32'(row_pos), 32'd2);
        chk("rerst.col", 32'(col_pos), 32'd10);
        chk("rerst.goal", 32'(goal_reached), 32'd0);
        chk("rerst.steps", 32'(step_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("final.pending_reads", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
